seq_detect_param: RTL and testbench

Parametrised Moore-style serial pattern detector. It is the generalised successor of the fixed 4-bit sequence detector.
- Pattern and pattern length are programmable at run time, up to MAX_LEN bits.
- Input bits are qualified by a valid strobe.
- Overlapping and non-overlapping detection are selectable.
- A saturating match counter is included.
- Sits on a serial bit stream (e.g. deserialiser or UART RX output) and flags frame/sync words to downstream control logic.

---
 rtl/seq_detect_param_if.sv | 40 ++++
 rtl/seq_detect_param.sv | 87 ++++++++
 tb/tb_seq_detect_param.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_param_if.sv
// Serial pattern detector bus: stream input, run-time configuration and match status.
// SEQ_DETECT_STICKY_EN adds the sticky match_seen status flag.
interface seq_detect_param_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               din;
  logic               din_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               overlap_en;
  logic               cnt_clr;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic [LEN_W-1:0]   busy_fill;
`ifdef SEQ_DETECT_STICKY_EN
  logic               match_seen;

  modport master (
    output din, din_valid, cfg_load, cfg_pattern, cfg_len, overlap_en, cnt_clr,
    input  detected, match_count, busy_fill, match_seen
  );
  modport slave (
    input  din, din_valid, cfg_load, cfg_pattern, cfg_len, overlap_en, cnt_clr,
    output detected, match_count, busy_fill, match_seen
  );
`else
  modport master (
    output din, din_valid, cfg_load, cfg_pattern, cfg_len, overlap_en, cnt_clr,
    input  detected, match_count, busy_fill
  );
  modport slave (
    input  din, din_valid, cfg_load, cfg_pattern, cfg_len, overlap_en, cnt_clr,
    output detected, match_count, busy_fill
  );
`endif
endinterface

// File: rtl/seq_detect_param.sv
// Run-time programmable serial pattern detector with overlap control and saturating match counter.
// Optional sticky match flag enabled by defining SEQ_DETECT_STICKY_EN.
module seq_detect_param #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_param_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic               detected_r;
  logic [CNT_W-1:0]   count_r;

  logic               sample;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] mask;
  logic               hit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_r));

    // A bit arriving alongside a config load is dropped.
    sample    = bus.din_valid & ~bus.cfg_load;
    hist_next = hist;
    fill_next = fill;
    if (sample) begin
      hist_next = {hist[MAX_LEN-2:0], bus.din};
      fill_next = (fill < len_r) ? fill + LEN_W'(1) : len_r;
    end

    hit = sample && (len_r != '0) && (fill_next >= len_r) &&
          (((hist_next ^ pat_r) & mask) == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r      <= '0;
      len_r      <= '0;
      hist       <= '0;
      fill       <= '0;
      detected_r <= 1'b0;
    end else if (bus.cfg_load) begin
      pat_r      <= bus.cfg_pattern;
      len_r      <= (bus.cfg_len > MAX_LEN_L) ? MAX_LEN_L : bus.cfg_len;
      hist       <= '0;
      fill       <= '0;
      detected_r <= 1'b0;
    end else begin
      hist       <= hist_next;
      // Non-overlapping mode restarts the fill so the next match needs len_r fresh bits.
      fill       <= (hit && !bus.overlap_en) ? '0 : fill_next;
      detected_r <= hit;
    end
  end

  // Clear beats a coincident match; the count saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) count_r <= '0;
    else if (hit && (count_r != '1)) count_r <= count_r + CNT_W'(1);
  end

`ifdef SEQ_DETECT_STICKY_EN
  logic seen_r;

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) seen_r <= 1'b0;
    else if (hit)           seen_r <= 1'b1;
  end

  assign bus.match_seen = seen_r;
`endif

  assign bus.detected    = detected_r;
  assign bus.match_count = count_r;
  assign bus.busy_fill   = fill;
endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios plus a randomized run
// against a bit-queue reference model. Define SEQ_DETECT_STICKY_EN to cover match_seen.
module tb_seq_detect_param;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_detect_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();
  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the recent valid bits as a queue, compared to the pattern bit by bit.
  bit               m_q[$];
  int               m_fill, m_len, m_cnt;
  logic [MAX_LEN-1:0] m_pat;
  bit               m_det, m_seen;

  function automatic void model_update();
    bit det_n, ok;
    det_n = 1'b0;
    if (rst) begin
      m_q.delete(); m_fill = 0; m_len = 0; m_pat = '0; m_cnt = 0; m_seen = 1'b0;
    end else begin
      if (bus.cfg_load) begin
        m_pat = bus.cfg_pattern;
        m_len = (int'(bus.cfg_len) > MAX_LEN) ? MAX_LEN : int'(bus.cfg_len);
        m_q.delete();
        m_fill = 0;
      end else if (bus.din_valid) begin
        m_q.push_back(bus.din);
        if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        m_fill = (m_fill + 1 > m_len) ? m_len : m_fill + 1;
        if (m_len != 0 && m_fill >= m_len) begin
          ok = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (m_q[m_q.size() - 1 - k] != m_pat[k]) ok = 1'b0;
          det_n = ok;
          if (ok && !bus.overlap_en) m_fill = 0;
        end
      end
      if (bus.cnt_clr) m_cnt = 0;
      else if (det_n && m_cnt < CNT_MAX) m_cnt++;
      if (bus.cnt_clr) m_seen = 1'b0;
      else if (det_n) m_seen = 1'b1;
    end
    m_det = det_n;
  endfunction

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.cfg_load  = 1'b0;
    bus.cnt_clr   = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic send(input bit d);
    bus.din = d; bus.din_valid = 1'b1;
    tick();
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input int l);
    bus.cfg_pattern = p; bus.cfg_len = LEN_W'(l); bus.cfg_load = 1'b1; bus.cnt_clr = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks += 3;
    if (bus.detected !== 1'b0) begin n_fail++; $display("FAIL reset_det: got %b want 0", bus.detected); end
    if (bus.match_count !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.match_count); end
    if (bus.busy_fill !== '0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", bus.busy_fill); end
    send(1'b1);
    n_checks++;
    if (bus.detected !== 1'b0) begin n_fail++; $display("FAIL reset_disabled: got %b want 0", bus.detected); end
  endtask

  task automatic test_overlap(input bit ovl);
    bit bits [7] = '{1, 0, 1, 1, 0, 1, 1};
    bit exp  [7];
    exp = ovl ? '{0, 0, 0, 1, 0, 0, 1} : '{0, 0, 0, 1, 0, 0, 0};
    bus.overlap_en = ovl;
    load(16'b1011, 4);
    for (int i = 0; i < 7; i++) begin
      send(bits[i]);
      n_checks++;
      if (bus.detected !== exp[i]) begin
        n_fail++; $display("FAIL ovl%0d_det bit%0d: got %b want %b", ovl, i + 1, bus.detected, exp[i]);
      end
    end
    n_checks++;
    if (bus.match_count !== CNT_W'(ovl ? 2 : 1)) begin
      n_fail++; $display("FAIL ovl%0d_cnt: got %0d want %0d", ovl, bus.match_count, ovl ? 2 : 1);
    end
    if (!ovl) begin
      n_checks++;
      if (bus.busy_fill !== LEN_W'(3)) begin n_fail++; $display("FAIL novl_fill: got %0d want 3", bus.busy_fill); end
    end
  endtask

  task automatic test_gap();
    bit vld [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    bit exp [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    bus.overlap_en = 1'b1;
    load(16'b111, 3);
    for (int i = 0; i < 8; i++) begin
      if (vld[i]) send(1'b1);
      else tick();
      n_checks++;
      if (bus.detected !== exp[i]) begin
        n_fail++; $display("FAIL gap_det step%0d: got %b want %b", i, bus.detected, exp[i]);
      end
    end
    n_checks++;
    if (bus.match_count !== CNT_W'(4)) begin n_fail++; $display("FAIL gap_cnt: got %0d want 4", bus.match_count); end
  endtask

  task automatic test_saturate();
    int want;
    bus.overlap_en = 1'b1;
    load(16'b1, 1);
    for (int i = 1; i <= CNT_MAX + 2; i++) begin
      send(1'b1);
      want = (i > CNT_MAX) ? CNT_MAX : i;
      n_checks += 2;
      if (bus.detected !== 1'b1) begin n_fail++; $display("FAIL sat_det bit%0d: got %b want 1", i, bus.detected); end
      if (bus.match_count !== CNT_W'(want)) begin
        n_fail++; $display("FAIL sat_cnt bit%0d: got %0d want %0d", i, bus.match_count, want);
      end
    end
    bus.cnt_clr = 1'b1;
    send(1'b1);
    n_checks += 2;
    if (bus.detected !== 1'b1) begin n_fail++; $display("FAIL clr_det: got %b want 1", bus.detected); end
    if (bus.match_count !== '0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", bus.match_count); end
    tick();
    n_checks++;
    if (bus.detected !== 1'b0) begin n_fail++; $display("FAIL clr_idle_det: got %b want 0", bus.detected); end
  endtask

  task automatic test_midstream();
    bus.overlap_en = 1'b1;
    load(16'b1011, 4);
    send(1'b1); send(1'b0); send(1'b1);
    load(16'b01, 2);
    send(1'b0);
    n_checks++;
    if (bus.detected !== 1'b0) begin n_fail++; $display("FAIL mid_det0: got %b want 0", bus.detected); end
    send(1'b1);
    n_checks += 2;
    if (bus.detected !== 1'b1) begin n_fail++; $display("FAIL mid_det1: got %b want 1", bus.detected); end
    if (bus.busy_fill !== LEN_W'(2)) begin n_fail++; $display("FAIL mid_fill: got %0d want 2", bus.busy_fill); end
    // Oversized length clamps to MAX_LEN: fill tops out there and all MAX_LEN bits are compared.
    load('1, 31);
    for (int i = 0; i < MAX_LEN + 4; i++) send(1'b0);
    n_checks++;
    if (bus.busy_fill !== LEN_W'(MAX_LEN)) begin
      n_fail++; $display("FAIL clamp_fill: got %0d want %0d", bus.busy_fill, MAX_LEN);
    end
    for (int i = 1; i <= MAX_LEN + 1; i++) begin
      send(1'b1);
      n_checks++;
      if (bus.detected !== (i >= MAX_LEN)) begin
        n_fail++; $display("FAIL clamp_det one%0d: got %b want %b", i, bus.detected, i >= MAX_LEN);
      end
    end
  endtask

  task automatic test_reset_midmatch();
    bus.overlap_en = 1'b1;
    load(16'b1011, 4);
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    tick();
`ifdef SEQ_DETECT_STICKY_EN
    n_checks++;
    if (bus.match_seen !== 1'b1) begin n_fail++; $display("FAIL sticky_hold: got %b want 1", bus.match_seen); end
    bus.cnt_clr = 1'b1;
    tick();
    n_checks++;
    if (bus.match_seen !== 1'b0) begin n_fail++; $display("FAIL sticky_clr: got %b want 0", bus.match_seen); end
`endif
    send(1'b1); send(1'b0); send(1'b1);
    rst = 1'b1;
    tick();
    send(1'b1);
    n_checks += 3;
    if (bus.detected !== 1'b0) begin n_fail++; $display("FAIL rstmid_det: got %b want 0", bus.detected); end
    if (bus.match_count !== '0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", bus.match_count); end
    if (bus.busy_fill !== '0) begin n_fail++; $display("FAIL rstmid_fill: got %0d want 0", bus.busy_fill); end
    for (int i = 0; i < 4; i++) begin
      send(i != 1);
      n_checks++;
      if (bus.detected !== 1'b0) begin n_fail++; $display("FAIL rstmid_nomatch bit%0d: got %b want 0", i, bus.detected); end
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 199);
      if (r < 4) begin
        bus.cfg_pattern = MAX_LEN'($urandom);
        bus.cfg_len     = (r == 0) ? LEN_W'($urandom_range(0, (1 << LEN_W) - 1)) : LEN_W'($urandom_range(1, 5));
        bus.cfg_load    = 1'b1;
      end
      if (r == 5) rst = 1'b1;
      if (r >= 6 && r < 14) bus.overlap_en = ~bus.overlap_en;
      bus.cnt_clr   = ($urandom_range(0, 49) == 0);
      bus.din_valid = ($urandom_range(0, 3) != 0);
      bus.din       = 1'($urandom);
      tick();
      n_checks += 3;
      if (bus.detected !== m_det) begin
        n_fail++; $display("FAIL rand_det cyc%0d: got %b want %b", c, bus.detected, m_det);
      end
      if (bus.match_count !== CNT_W'(m_cnt)) begin
        n_fail++; $display("FAIL rand_cnt cyc%0d: got %0d want %0d", c, bus.match_count, m_cnt);
      end
      if (bus.busy_fill !== LEN_W'(m_fill)) begin
        n_fail++; $display("FAIL rand_fill cyc%0d: got %0d want %0d", c, bus.busy_fill, m_fill);
      end
`ifdef SEQ_DETECT_STICKY_EN
      n_checks++;
      if (bus.match_seen !== m_seen) begin
        n_fail++; $display("FAIL rand_seen cyc%0d: got %b want %b", c, bus.match_seen, m_seen);
      end
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.cfg_load = 1'b0; bus.cfg_pattern = '0;
    bus.cfg_len = '0; bus.overlap_en = 1'b1; bus.cnt_clr = 1'b0;
    m_q.delete(); m_fill = 0; m_len = 0; m_cnt = 0; m_pat = '0; m_det = 1'b0; m_seen = 1'b0;
    @(negedge clk);
    test_reset();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_gap();
    test_saturate();
    test_midstream();
    test_reset_midmatch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
